shift_rotate_unit: RTL and testbench
====================================

Name: shift_rotate_unit

Overview:
Multi-cycle, parametrised shift/rotate execution unit for the datapath ALU, the successor to the single-cycle SHR path.
- Supports SHR, SHRA, SHL, ROR and ROL at any WIDTH, shifting STEP bit positions per clock.
- Uses a start/busy/done handshake, so the control sequencer can stall the execute step (T4) until the result is ready to be driven to Zlow.
- Sits between the Y/bus operands and the Z register input.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
STEP, 1, bit positions shifted per RUN cycle; power of two, 1..WIDTH

Ports:
Clock  in  1  system clock, rising edge
Clear  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
mode  in  3  operation select, encodings in package
operand  in  WIDTH  value to shift (Y contents)
amount  in  WIDTH  shift count (bus register contents), unsigned
busy  out  1  unit occupied (RUN or DONE)
done  out  1  one-cycle pulse, result valid
result  out  WIDTH  shifted value, held until the next accepted start

Behaviour:
- One clock domain. Clear is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, internal count=0, mode register=PASS.
- States: IDLE, RUN, DONE.
- IDLE with start=1: latch operand into the working register and latch mode.
  - Effective count for SHR/SHRA/SHL: min(amount, WIDTH).
  - Effective count for ROR/ROL: amount mod WIDTH.
  - Effective count for PASS (undefined mode codes 5..7): 0.
  - If effective count = 0, go to DONE; otherwise go to RUN.
- RUN: each cycle shift the working register by k = min(STEP, remaining) and decrement remaining by k. Go to DONE in the cycle remaining becomes 0.
- Per-mode shift rules:
  - SHR zero-fills from the MSB side.
  - SHRA replicates the sign bit of the latched operand.
  - SHL zero-fills from the LSB side.
  - ROR/ROL wrap the bits around.
- DONE: done=1 and busy=1 for exactly one cycle, result = working register, then return to IDLE.
- result updates only on the DONE transition and is stable in IDLE.
- Latency: start accepted at edge N; done high during cycle N+1+ceil(count/STEP). Count 0 gives done in cycle N+1.
- busy is high from the cycle after the start edge through the DONE cycle.
- start while busy: ignored, with no queuing. start in the DONE cycle is also ignored.
- Operand, mode and amount changes after acceptance have no effect.
- Shift by >= WIDTH: SHR/SHL result=0; SHRA result = all sign bits.
- Clear mid-operation aborts immediately to the reset values. No done pulse is issued.

Optional Feature:
Macro SHIFT_CARRY_EN.
- Defined: extra output port carry (1 bit), updated alongside result.
  - carry = last bit shifted or rotated out (for ROR, the final bit moved out of bit 0; for ROL, out of bit WIDTH-1).
  - carry = 0 when effective count = 0.
  - Reset value 0.
- Undefined: port absent, no carry logic; the rest of the behaviour is identical.

Decomposition:
- Package shift_pkg:
  - Mode encodings: SHR=3'd0, SHRA=3'd1, SHL=3'd2, ROR=3'd3, ROL=3'd4, PASS=others.
  - State enum (IDLE/RUN/DONE).
  - clog2 helper for the count width.
- Sub-module shift_step: combinational; shifts a WIDTH-bit value by 0..STEP positions for a given mode and fill bit. Instantiated once in the RUN path.

Test Plan:
1. WIDTH=32, STEP=1; SHR operand=0x80000012, amount=4 -> result=0x08000001; done in cycle N+5; busy high for 5 cycles.
2. Same operand, amount=4: SHRA -> 0xF8000001; SHL -> 0x00000120; ROR -> 0x28000001; ROL -> 0x00000128.
3. Out-of-range amounts, operand=0x80000012:
   - SHR amount=40 -> 0x00000000.
   - SHRA amount=40 -> 0xFFFFFFFF.
   - ROL amount=36 -> 0x00000128 (4 run cycles).
   - Amount=0 -> result=operand, done at N+1.
4. STEP=8; ROR 0x12345678 amount=12 -> 0x67812345; done at N+3.
   With SHIFT_CARRY_EN: carry = bit 11 of the operand = 0; SHR 0x00000018 amount=4 -> carry=1.
5. Handshake: assert start again during RUN with different operands -> ignored, first result unchanged. Pulse start in IDLE after done -> new operation accepted.
6. Start SHR amount=20, assert Clear in RUN cycle 5 -> busy=0, done=0, result=0 asynchronously. No done pulse follows; the next start operates normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared mode/state encodings and sizing helper for the shift/rotate unit.
// Optional carry output is enabled by defining SHIFT_CARRY_EN.
package shift_pkg;

   typedef enum logic [2:0] {
      MODE_SHR  = 3'd0,
      MODE_SHRA = 3'd1,
      MODE_SHL  = 3'd2,
      MODE_ROR  = 3'd3,
      MODE_ROL  = 3'd4,
      MODE_PASS = 3'd5
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Codes 5..7 are undefined and collapse to PASS.
   function automatic mode_e decode_mode(input logic [2:0] code);
      case (code)
         3'd0, 3'd1, 3'd2, 3'd3, 3'd4: return mode_e'(code);
         default:                      return MODE_PASS;
      endcase
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shifter: moves a WIDTH-bit value by 0..STEP positions.
// With SHIFT_CARRY_EN defined it also reports the last bit moved out.
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 1,
   localparam int unsigned KW   = clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] value,
   input  mode_e            mode,
   input  logic             fill,
   input  logic [KW-1:0]    k,
   output logic [WIDTH-1:0] shifted
`ifdef SHIFT_CARRY_EN
   ,output logic            carry_out
`endif
);

   logic             is_left;
   logic [KW-1:0]    k_eff;
   logic [WIDTH-1:0] hi_fill;
   logic [WIDTH-1:0] lo_fill;

   always_comb begin
      is_left = (mode == MODE_SHL) || (mode == MODE_ROL);
      k_eff   = (mode == MODE_PASS) ? '0 : k;
      hi_fill = (mode == MODE_ROR) ? value : {WIDTH{fill}};
      lo_fill = (mode == MODE_ROL) ? value : '0;
   end

`ifdef SHIFT_CARRY_EN
   // An extra guard bit on each side captures the last bit shifted out.
   logic [WIDTH:0] right_out;
   logic [WIDTH:0] left_out;

   always_comb begin
      right_out = (WIDTH+1)'({hi_fill, value, 1'b0} >> k_eff);
      left_out  = (WIDTH+1)'(({1'b0, value, lo_fill} << k_eff) >> WIDTH);
   end

   assign shifted   = is_left ? left_out[WIDTH-1:0] : right_out[WIDTH:1];
   assign carry_out = is_left ? left_out[WIDTH] : right_out[0];
`else
   logic [WIDTH-1:0] right_out;
   logic [WIDTH-1:0] left_out;

   always_comb begin
      right_out = WIDTH'({hi_fill, value} >> k_eff);
      left_out  = WIDTH'(({value, lo_fill} << k_eff) >> WIDTH);
   end

   assign shifted = is_left ? left_out : right_out;
`endif

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit with start/busy/done handshake, STEP bits per cycle.
// Define SHIFT_CARRY_EN to add the carry output (last bit shifted out).
module shift_rotate_unit
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 1
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] operand,
   input  logic [WIDTH-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
`ifdef SHIFT_CARRY_EN
   ,output logic            carry
`endif
);

   localparam int unsigned      CW      = clog2(WIDTH + 1);
   localparam int unsigned      KW      = clog2(STEP + 1);
   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
   localparam logic [CW-1:0]    STEP_C  = CW'(STEP);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [CW-1:0]    rem_q, rem_d;
   mode_e            mode_q, mode_d;
   logic             fill_q, fill_d;
   logic [WIDTH-1:0] result_q, result_d;

   mode_e            mode_in;
   logic [CW-1:0]    eff_cnt;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] step_out;
`ifdef SHIFT_CARRY_EN
   logic             carry_q, carry_d;
   logic             step_carry;
`endif

   always_comb begin
      mode_in = decode_mode(mode);
      case (mode_in)
         MODE_SHR, MODE_SHRA, MODE_SHL:
            eff_cnt = (amount >= WIDTH_V) ? CW'(WIDTH) : amount[CW-1:0];
         MODE_ROR, MODE_ROL:
            eff_cnt = CW'(amount % WIDTH_V);
         default:
            eff_cnt = '0;
      endcase
      k = (rem_q >= STEP_C) ? KW'(STEP) : rem_q[KW-1:0];
   end

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .value     (work_q),
      .mode      (mode_q),
      .fill      (fill_q),
      .k         (k),
      .shifted   (step_out)
`ifdef SHIFT_CARRY_EN
      ,.carry_out (step_carry)
`endif
   );

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      rem_d    = rem_q;
      mode_d   = mode_q;
      fill_d   = fill_q;
      result_d = result_q;
`ifdef SHIFT_CARRY_EN
      carry_d  = carry_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               work_d = operand;
               mode_d = mode_in;
               fill_d = (mode_in == MODE_SHRA) && operand[WIDTH-1];
               rem_d  = eff_cnt;
               if (eff_cnt == '0) begin
                  state_d  = ST_DONE;
                  result_d = operand;
`ifdef SHIFT_CARRY_EN
                  carry_d  = 1'b0;
`endif
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            work_d = step_out;
            rem_d  = rem_q - CW'(k);
            // Result is captured on the edge into DONE so it is valid with the pulse.
            if (rem_q == CW'(k)) begin
               state_d  = ST_DONE;
               result_d = step_out;
`ifdef SHIFT_CARRY_EN
               carry_d  = step_carry;
`endif
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q  <= ST_IDLE;
         work_q   <= '0;
         rem_q    <= '0;
         mode_q   <= MODE_PASS;
         fill_q   <= 1'b0;
         result_q <= '0;
`ifdef SHIFT_CARRY_EN
         carry_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         rem_q    <= rem_d;
         mode_q   <= mode_d;
         fill_q   <= fill_d;
         result_q <= result_d;
`ifdef SHIFT_CARRY_EN
         carry_q  <= carry_d;
`endif
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
`ifdef SHIFT_CARRY_EN
   assign carry  = carry_q;
`endif

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench for shift_rotate_unit (STEP=1 and STEP=8 instances side by side).
// Carry checks are included when SHIFT_CARRY_EN is defined.
module tb_shift_rotate_unit;

   logic        Clock = 1'b0;
   logic        Clear;
   logic        start;
   logic [2:0]  mode;
   logic [31:0] operand, amount;
   logic        busy1, done1, busy8, done8;
   logic [31:0] result1, result8;
`ifdef SHIFT_CARRY_EN
   logic        carry1, carry8;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clock = ~Clock;

   shift_rotate_unit #(.WIDTH(32), .STEP(1)) dut1 (
      .Clock(Clock), .Clear(Clear), .start(start), .mode(mode),
      .operand(operand), .amount(amount), .busy(busy1), .done(done1),
      .result(result1)
`ifdef SHIFT_CARRY_EN
      , .carry(carry1)
`endif
   );

   shift_rotate_unit #(.WIDTH(32), .STEP(8)) dut8 (
      .Clock(Clock), .Clear(Clear), .start(start), .mode(mode),
      .operand(operand), .amount(amount), .busy(busy8), .done(done8),
      .result(result8)
`ifdef SHIFT_CARRY_EN
      , .carry(carry8)
`endif
   );

   typedef struct {
      logic [2:0]  m;
      logic [31:0] op;
      logic [31:0] amt;
      logic [31:0] res;
      bit          c;
      int          l1;
      int          l8;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Reference: bit-by-bit definition of each operation plus latency formula.
   task automatic model(input logic [2:0] m, input logic [31:0] op, input logic [31:0] amt,
                        output logic [31:0] res, output bit c, output int l1, output int l8);
      int n;
      case (m)
         3'd0, 3'd1, 3'd2: n = (amt >= 32) ? 32 : int'(amt);
         3'd3, 3'd4:       n = int'(amt % 32);
         default:          n = 0;
      endcase
      for (int i = 0; i < 32; i++) begin
         case (m)
            3'd0:    res[i] = (i + n < 32) ? op[i + n] : 1'b0;
            3'd1:    res[i] = (i + n < 32) ? op[i + n] : op[31];
            3'd2:    res[i] = (i - n >= 0) ? op[i - n] : 1'b0;
            3'd3:    res[i] = op[(i + n) % 32];
            3'd4:    res[i] = op[(i - n + 32) % 32];
            default: res[i] = op[i];
         endcase
      end
      if (n == 0)                 c = 1'b0;
      else if (m == 3'd2 || m == 3'd4) c = op[32 - n];
      else                        c = op[n - 1];
      l1 = 1 + n;
      l8 = 1 + (n + 7) / 8;
   endtask

   // Issue one operation to both units; optionally re-assert start at cycle inj.
   task automatic run_op(input logic [2:0] m, input logic [31:0] op, input logic [31:0] amt,
                         input logic [31:0] er, input bit ec, input int el1, input int el8,
                         input int inj);
      int lat1 = 0, lat8 = 0, bad1 = 0, bad8 = 0, extra = 0;
      logic [31:0] r1 = '0, r8 = '0;
`ifdef SHIFT_CARRY_EN
      logic c1 = 1'b0, c8 = 1'b0;
`endif
      mode = m; operand = op; amount = amt; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 40 && (lat1 == 0 || lat8 == 0); c++) begin
         if (lat1 == 0) begin
            if (!busy1) bad1++;
            if (done1) begin
               lat1 = c; r1 = result1;
`ifdef SHIFT_CARRY_EN
               c1 = carry1;
`endif
            end
         end else if (done1) extra++;
         if (lat8 == 0) begin
            if (!busy8) bad8++;
            if (done8) begin
               lat8 = c; r8 = result8;
`ifdef SHIFT_CARRY_EN
               c8 = carry8;
`endif
            end
         end else if (done8) extra++;
         // Inputs wander after acceptance; they must not matter.
         mode = 3'($urandom); operand = $urandom; amount = $urandom;
         if (c == inj) start = 1'b1;
         tick();
         start = 1'b0;
      end
      check("latency step1", lat1, el1);
      check("latency step8", lat8, el8);
      check("result step1", r1, er);
      check("result step8", r8, er);
      check("busy gaps", bad1 + bad8, 0);
      check("extra done", extra, 0);
`ifdef SHIFT_CARRY_EN
      check("carry step1", 32'(c1), 32'(ec));
      check("carry step8", 32'(c8), 32'(ec));
`endif
      check("idle busy", {busy1, busy8, done1, done8}, 0);
      check("held result step1", result1, er);
      check("held result step8", result8, er);
   endtask

   initial begin
      vec_t vecs[$];
      logic [2:0]  rm;
      logic [31:0] rop, ramt, rres;
      bit          rc;
      int          rl1, rl8, pulses;

      vecs.push_back('{3'd0, 32'h80000012, 32'd4,  32'h08000001, 1'b0, 5,  2});
      vecs.push_back('{3'd1, 32'h80000012, 32'd4,  32'hF8000001, 1'b0, 5,  2});
      vecs.push_back('{3'd2, 32'h80000012, 32'd4,  32'h00000120, 1'b0, 5,  2});
      vecs.push_back('{3'd3, 32'h80000012, 32'd4,  32'h28000001, 1'b0, 5,  2});
      vecs.push_back('{3'd4, 32'h80000012, 32'd4,  32'h00000128, 1'b0, 5,  2});
      vecs.push_back('{3'd0, 32'h80000012, 32'd40, 32'h00000000, 1'b1, 33, 5});
      vecs.push_back('{3'd1, 32'h80000012, 32'd40, 32'hFFFFFFFF, 1'b1, 33, 5});
      vecs.push_back('{3'd4, 32'h80000012, 32'd36, 32'h00000128, 1'b0, 5,  2});
      vecs.push_back('{3'd0, 32'h80000012, 32'd0,  32'h80000012, 1'b0, 1,  1});
      vecs.push_back('{3'd3, 32'h12345678, 32'd12, 32'h67812345, 1'b0, 13, 3});
      vecs.push_back('{3'd0, 32'h00000018, 32'd4,  32'h00000001, 1'b1, 5,  2});
      vecs.push_back('{3'd6, 32'hCAFEF00D, 32'd7,  32'hCAFEF00D, 1'b0, 1,  1});
      vecs.push_back('{3'd2, 32'h80000012, 32'd32, 32'h00000000, 1'b0, 33, 5});
      vecs.push_back('{3'd3, 32'hA5A50F0F, 32'd32, 32'hA5A50F0F, 1'b0, 1,  1});

      Clear = 1'b1; start = 1'b0; mode = '0; operand = '0; amount = '0;
      #12;
      check("reset busy/done", {busy1, done1, busy8, done8}, 0);
      check("reset result step1", result1, 0);
      check("reset result step8", result8, 0);
`ifdef SHIFT_CARRY_EN
      check("reset carry", {carry1, carry8}, 0);
`endif
      @(negedge Clock);
      Clear = 1'b0;
      tick();

      foreach (vecs[i])
         run_op(vecs[i].m, vecs[i].op, vecs[i].amt, vecs[i].res, vecs[i].c,
                vecs[i].l1, vecs[i].l8, 0);

      // start during RUN (STEP=1) and during DONE (STEP=8) must be ignored
      run_op(3'd0, 32'h80000012, 32'd4, 32'h08000001, 1'b0, 5, 2, 2);
      run_op(3'd4, 32'h80000012, 32'd4, 32'h00000128, 1'b0, 5, 2, 0);

      // Clear in RUN cycle 5 aborts at once with no done pulse afterwards
      mode = 3'd0; operand = 32'hDEADBEEF; amount = 32'd20; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("busy before clear", 32'(busy1), 1);
      #2 Clear = 1'b1;
      #1;
      check("clear busy/done", {busy1, done1, busy8, done8}, 0);
      check("clear result step1", result1, 0);
      check("clear result step8", result8, 0);
`ifdef SHIFT_CARRY_EN
      check("clear carry", {carry1, carry8}, 0);
`endif
      #2 Clear = 1'b0;
      tick();
      pulses = 0;
      repeat (30) begin
         if (done1 || done8 || busy1 || busy8) pulses++;
         tick();
      end
      check("activity after clear", pulses, 0);
      run_op(3'd1, 32'h80000012, 32'd4, 32'hF8000001, 1'b0, 5, 2, 0);

      repeat (40) begin
         rm   = 3'($urandom_range(0, 7));
         rop  = $urandom;
         ramt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
         model(rm, rop, ramt, rres, rc, rl1, rl8);
         run_op(rm, rop, ramt, rres, rc, rl1, rl8, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
